// File: rtl/clk_gate_pkg.sv
// Shared constants and types for the clk_gate_icg clock-gating block.
// The optional per-gate activity counters are built only when the
// CLK_GATE_STATS_EN macro is defined.
package clk_gate_pkg;

    // Default width of one per-gate activity counter.
    localparam int CntWidthDefault = 16;

    // Largest number of independent gated outputs one instance supports.
    localparam int MaxGates = 64;

    // Activity counter at the default width.
    typedef logic [CntWidthDefault-1:0] gate_cnt_t;

endpackage : clk_gate_pkg

// File: rtl/clk_gate_icg_if.sv
// Signal bundle between a clock-gate controller and the clk_gate_icg block.
// The controller side (master) drives the enables and test override.
// The gating block (slave) returns the gated clocks and latched enables.
// With CLK_GATE_STATS_EN defined, the per-gate activity counters are added.
// NumGates and CntWidth must match the parameters of the clk_gate_icg
// instance this bundle is connected to.
interface clk_gate_icg_if #(
    parameter int NumGates = 1,
    parameter int CntWidth = clk_gate_pkg::CntWidthDefault
);

    logic [NumGates-1:0]          en_i;
    logic                         test_en_i;
    logic [NumGates-1:0]          clk_o;
    logic [NumGates-1:0]          en_status_o;
`ifdef CLK_GATE_STATS_EN
    logic [NumGates*CntWidth-1:0] cnt_o;
`endif

`ifdef CLK_GATE_STATS_EN
    modport master (
        output en_i,
        output test_en_i,
        input  clk_o,
        input  en_status_o,
        input  cnt_o
    );

    modport slave (
        input  en_i,
        input  test_en_i,
        output clk_o,
        output en_status_o,
        output cnt_o
    );
`else
    modport master (
        output en_i,
        output test_en_i,
        input  clk_o,
        input  en_status_o
    );

    modport slave (
        input  en_i,
        input  test_en_i,
        output clk_o,
        output en_status_o
    );
`endif

endinterface : clk_gate_icg_if

// File: rtl/clk_gate_cell.sv
// One latch-based integrated clock-gating cell.
// The enable latch is transparent while clk_i is low and holds while clk_i
// is high, so the AND gate can only ever pass complete high phases.
// Reset closes the latch immediately, whatever the clock is doing.
// A target flow may replace this cell with a library ICG of equal behaviour.
module clk_gate_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o,
    output logic en_q_o
);

    logic en_l;

    // Low-phase-transparent enable latch with asynchronous clear.
    // NOTE: this latch is intentional -- it is the whole point of the cell.
    // always_latch states the intent, and every path either clears, loads
    // or deliberately holds en_l; no other latch may exist in this design.
    always_latch begin
        if (rst_i) begin
            en_l <= 1'b0;
        end else if (!clk_i) begin
            en_l <= en_i | test_en_i;
        end
    end

    // Gated clock: the latch is frozen for the whole high phase, so no glitch.
    assign clk_o  = clk_i & en_l;
    assign en_q_o = en_l;

endmodule : clk_gate_cell

// File: rtl/clk_gate_icg.sv
// Multi-output integrated clock-gating block.
// Produces NumGates glitch-free gated copies of clk_i, one per enable bit,
// all sharing a single test override that forces every gate open.
// Optional feature macro: CLK_GATE_STATS_EN adds one saturating counter per
// gate that counts passed rising edges; without it no counter logic exists.
module clk_gate_icg
    import clk_gate_pkg::*;
#(
    parameter int NumGates = 1,
    parameter int CntWidth = CntWidthDefault
) (
    input  logic          clk_i,
    input  logic          rst_i,
    clk_gate_icg_if.slave bus
);

    // Latched enables of all gates, the only state in the default build.
    logic [NumGates-1:0] en_q;
    logic [NumGates-1:0] clk_gated;

    for (genvar g = 0; g < NumGates; g++) begin : g_cell
        clk_gate_cell u_cell (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (bus.en_i[g]),
            .test_en_i (bus.test_en_i),
            .clk_o     (clk_gated[g]),
            .en_q_o    (en_q[g])
        );
    end

    assign bus.clk_o       = clk_gated;
    assign bus.en_status_o = en_q;

`ifdef CLK_GATE_STATS_EN
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic [CntWidth-1:0]          cnt_q [NumGates];
    logic [NumGates*CntWidth-1:0] cnt_flat;

    // Count clk_i rising edges on which each gate is open; stick at all-ones.
    // en_q is frozen across the rising edge, so it equals the gate's decision.
    // NOTE: state registers use non-blocking assignment so every counter
    // updates from pre-edge values; blocking here would race with readers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int g = 0; g < NumGates; g++) begin
                cnt_q[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NumGates; g++) begin
                if (en_q[g] && (cnt_q[g] != CntMax)) begin
                    cnt_q[g] <= cnt_q[g] + CntWidth'(1);
                end
            end
        end
    end

    // Pack the per-gate counters into the flat output, gate g at slice g.
    // NOTE: cnt_flat gets a full default before the loop so no path can
    // leave a bit unassigned and infer a latch.
    always_comb begin
        cnt_flat = '0;
        for (int g = 0; g < NumGates; g++) begin
            cnt_flat[g*CntWidth +: CntWidth] = cnt_q[g];
        end
    end

    assign bus.cnt_o = cnt_flat;
`endif

endmodule : clk_gate_icg

// File: tb/tb_clk_gate_icg.sv
// Self-checking bench for clk_gate_icg with four gates and 4-bit counters.
// A cycle-level model predicts which gates open on each high phase and how
// many edges each gate has passed; an edge monitor counts real output
// pulses and flags any pulse shorter than half a clock period.
`timescale 1ns/1ps
module tb_clk_gate_icg;

    localparam int  NG      = 4;
    localparam int  CW      = 4;
    localparam int  CNT_MAX = (1 << CW) - 1;
    localparam real HALF    = 5.0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    clk_gate_icg_if #(.NumGates(NG), .CntWidth(CW)) bus ();

    clk_gate_icg #(.NumGates(NG), .CntWidth(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected passed pulses and expected counter values.
    int model_rises [NG];
    int model_cnt   [NG];

    // Observed output activity.
    int            rises  [NG];
    realtime       t_rise [NG];
    int            narrow = 0;
    bit            allow_trunc = 1'b0;
    logic [NG-1:0] prev_clk_o = '0;

    // Edge monitor on the gated clocks.
    always @(bus.clk_o) begin
        for (int g = 0; g < NG; g++) begin
            if (prev_clk_o[g] !== 1'b1 && bus.clk_o[g] === 1'b1) begin
                rises[g]++;
                t_rise[g] = $realtime;
            end else if (prev_clk_o[g] === 1'b1 && bus.clk_o[g] !== 1'b1) begin
                if (($realtime - t_rise[g]) < HALF && !allow_trunc) narrow++;
            end
        end
        prev_clk_o = bus.clk_o;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef CLK_GATE_STATS_EN
        for (int g = 0; g < NG; g++) begin
            check($sformatf("%s/cnt%0d", tag, g),
                  64'(bus.cnt_o[g*CW +: CW]), 64'(model_cnt[g]));
        end
`endif
    endtask

    task automatic check_rises(input string tag);
        for (int g = 0; g < NG; g++) begin
            check($sformatf("%s/rises%0d", tag, g), 64'(rises[g]), 64'(model_rises[g]));
        end
    endtask

    // One clock cycle: drive en_low/t_low during the low phase, predict the
    // next high phase from the OR rule, then disturb the inputs mid-high and
    // confirm the running pulse is unaffected.
    task automatic phase(input logic [NG-1:0] en_low, input logic t_low,
                         input logic [NG-1:0] en_high, input logic t_high,
                         input string tag);
        logic [NG-1:0] exp;
        @(negedge clk);
        #1;
        bus.en_i      = en_low;
        bus.test_en_i = t_low;
        exp = en_low | {NG{t_low}};
        @(posedge clk);
        #1;
        check({tag, "/clk_o"}, 64'(bus.clk_o), 64'(exp));
        check({tag, "/status"}, 64'(bus.en_status_o), 64'(exp));
        for (int g = 0; g < NG; g++) begin
            if (exp[g]) begin
                model_rises[g]++;
                if (model_cnt[g] < CNT_MAX) model_cnt[g]++;
            end
        end
        #1;
        bus.en_i      = en_high;
        bus.test_en_i = t_high;
        #1;
        check({tag, "/hold"}, 64'(bus.clk_o), 64'(exp));
    endtask

    initial begin
        logic [NG-1:0] r_lo;
        logic [NG-1:0] r_hi;
        logic [NG-1:0] glitch_mask;

        for (int g = 0; g < NG; g++) begin
            model_rises[g] = 0;
            model_cnt[g]   = 0;
            rises[g]       = 0;
            t_rise[g]      = 0.0;
        end

        // Reset held with every enable and the override asserted.
        bus.en_i      = '1;
        bus.test_en_i = 1'b1;
        rst           = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset/clk_o", 64'(bus.clk_o), 64'(0));
            check("reset/status", 64'(bus.en_status_o), 64'(0));
            check_counters("reset");
        end

        // Release reset during a low phase with all gates closed.
        @(negedge clk);
        #1;
        bus.en_i      = '0;
        bus.test_en_i = 1'b0;
        rst           = 1'b0;

        // Gates 0 and 2 enabled for five cycles.
        repeat (5) phase(4'b0101, 1'b0, 4'b0101, 1'b0, "en0101");
        phase(4'b0000, 1'b0, 4'b0000, 1'b0, "idle");
        check_rises("en0101");
        check_counters("en0101");

        // Enable pulse on gate 0 confined to high phases must never pass.
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.en_i = 4'b0001;
            #2;
            bus.en_i = 4'b0000;
            #1;
            glitch_mask = bus.clk_o | bus.en_status_o;
            check("glitch/gate0", 64'(glitch_mask[0]), 64'(0));
        end
        check_rises("glitch");

        // Test override opens every gate regardless of en_i.
        repeat (4) phase(4'b0000, 1'b1, 4'b0000, 1'b1, "test_en");
        phase(4'b0000, 1'b0, 4'b0000, 1'b0, "idle2");
        check_rises("test_en");
        check_counters("test_en");

        // Reset asserted in the middle of a passed high phase.
        phase(4'b0001, 1'b0, 4'b0001, 1'b0, "pre_rst");
        allow_trunc = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_async/clk_o", 64'(bus.clk_o), 64'(0));
        check("rst_async/status", 64'(bus.en_status_o), 64'(0));
        for (int g = 0; g < NG; g++) model_cnt[g] = 0;
        check_counters("rst_async");
        allow_trunc = 1'b0;

        // Reset released while clk is high: nothing until the next full phase.
        @(posedge clk);
        #1;
        check("rst_held/clk_o", 64'(bus.clk_o), 64'(0));
        #1;
        rst = 1'b0;
        #1;
        check("rst_rel_high/clk_o", 64'(bus.clk_o), 64'(0));
        check("rst_rel_high/status", 64'(bus.en_status_o), 64'(0));
        phase(4'b0001, 1'b0, 4'b0001, 1'b0, "first_after_rst");
        check_rises("after_rst");

        // Randomised enables and override, with random mid-high disturbance.
        repeat (40) begin
            r_lo = NG'($urandom);
            r_hi = NG'($urandom);
            phase(r_lo, ($urandom_range(0, 3) == 0), r_hi, 1'($urandom_range(0, 1)), "rand");
        end
        phase(4'b0000, 1'b0, 4'b0000, 1'b0, "idle3");
        check_rises("rand");
        check_counters("rand");

        // Long run on gate 0 drives its counter into saturation.
        repeat (20) phase(4'b0001, 1'b0, 4'b0001, 1'b0, "sat");
`ifdef CLK_GATE_STATS_EN
        check("sat/cnt0_allones", 64'(bus.cnt_o[CW-1:0]), 64'(4'hF));
`endif
        check_counters("sat");
        check_rises("sat");

        check("narrow_pulses", 64'(narrow), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_clk_gate_icg

// File: doc/clk_gate_icg.md
Name: clk_gate_icg

Overview:
- Latch-based integrated clock-gating (ICG) block producing NumGates glitch-free gated copies of one input clock.
- Each output has its own enable; all share one test override.
- Used as a global write-clock gate and as per-word clock gates in latch-based register files and other clock-gated storage.
- Behavioural, technology-independent; a target flow may swap each bit-cell for a library ICG with identical behaviour.

Parameters:
- NumGates, 1, number of independent gated clock outputs (1..64).
- CntWidth, 16, width of each activity counter (used only with CLK_GATE_STATS_EN).

Ports:
- clk_i  input  1  free-running source clock.
- rst_i  input  1  asynchronous active-high reset; forces all enable latches closed.
- en_i  input  NumGates  functional enable per output; must be stable around the clk_i rising edge.
- test_en_i  input  1  scan/test override; forces every output enabled.
- clk_o  output  NumGates  gated clocks.
- en_status_o  output  NumGates  current latched enable per gate, for observability.
- cnt_o  output  NumGates*CntWidth  per-gate count of passed rising edges; present only with CLK_GATE_STATS_EN. Gate g occupies bits [g*CntWidth +: CntWidth].

Behaviour:
- Per gate g: en_eff[g] = en_i[g] | test_en_i.
- Enable latch en_l[g] is transparent while clk_i is low and holds while clk_i is high.
- clk_o[g] = clk_i & en_l[g].
- en_status_o[g] = en_l[g].
- Latency: an enable sampled while clk_i is low gates the next high phase of clk_i. Zero cycles from enable to the first passed edge.
- Changes of en_i while clk_i is high have no effect on the current high phase. No truncated pulses or glitches on clk_o.
- Reset: while rst_i = 1, en_l = 0 for all gates, asynchronously and immediately. clk_o = 0 and en_status_o = 0, regardless of clk_i or test_en_i.
- Reset asserted while clk_i is high: clk_o drops to 0 immediately. This truncated pulse is the only permitted one.
- Reset deasserted while clk_i is high: en_l stays 0 until clk_i goes low. The first possible output pulse is the next full high phase.
- test_en_i = 1: all gates pass clk_i from the next low-to-high transition on, independent of en_i.
- Simultaneous changes on en_i and test_en_i follow the OR rule.
- Gates are fully independent: one enable must not affect another output.
- No internal state besides en_l (and counters, when the stats feature is enabled).

Optional Feature:
- Macro: CLK_GATE_STATS_EN.
- Defined:
  - cnt_o exists.
  - Counter g increments on each rising edge of clk_i where en_l[g] = 1 (i.e. each clk_o[g] rising edge).
  - Counters saturate at all-ones and do not wrap.
  - Counters reset asynchronously to 0 on rst_i.
- Undefined: no cnt_o port, no counters, no added logic.

Decomposition:
- Package clk_gate_pkg:
  - localparam CntWidthDefault = 16.
  - localparam MaxGates = 64.
  - typedef logic [CntWidthDefault-1:0] gate_cnt_t.
- Sub-module clk_gate_cell: one bit with clk_i, rst_i, en_i, test_en_i, clk_o and en_q_o. The top generates NumGates instances plus the optional counters.

Test Plan:
- Reset, NumGates=4, rst_i=1 with en_i=4'b1111 and test_en_i=1 over 3 clk_i cycles -> clk_o=0 and en_status_o=0 throughout. cnt_o=0 (with stats).
- en_i=4'b0101 set while clk_i is low, held 5 cycles -> clk_o[0] and clk_o[2] toggle exactly 5 times, clk_o[1] and clk_o[3] stay 0. cnt_o gate0 = 5 and gate2 = 5.
- Glitch check: en_i[0] toggled 0->1->0 entirely within clk_i high phases -> clk_o[0] never rises, no pulse narrower than half a clk_i period.
- test_en_i=1 with en_i=0 for 4 cycles -> all clk_o follow clk_i for 4 full pulses. en_status_o=4'b1111.
- Reset asserted mid-high-phase with en_i=1 -> clk_o falls the same instant. Deassert while clk_i is high -> no output pulse until the following full high phase.
- CntWidth=4 with stats, en_i[0]=1 for 20 cycles -> cnt_o gate0 = 15 (saturated), not 4.
